// File: rtl/bbqm_queue_ctrl.sv
// bbqm_queue_ctrl: parametrised bank-queue controller with tick-sampled
// buttons, occupancy FSM, arithmetic wait time and optional 7-seg decoders.
//
// Ports:
//   CLK          system clock
//   reset        asynchronous active-low reset
//   enter_queue  raw enter button (asynchronous, bouncy)
//   leave_queue  raw leave button (asynchronous, bouncy)
//   tcount       active teller count
//   pcount       customers in queue
//   wtime        expected wait in minutes
//   full_led     pcount == MAX_COUNT
//   empty_led    pcount == 0
//   alarm        sticky illegal-request flag
//   seg_units    7-seg wtime units digit (active-high a..g)
//   seg_tens     7-seg wtime tens digit
//   seg_count    7-seg pcount digit, clamped to 9
//
// Build option: define BBQM_SEG7_EN to build the segment decoders;
// otherwise all seg_* outputs are tied to zero.
module bbqm_queue_ctrl #(
    parameter int MAX_COUNT = 7,
    parameter int CNT_W     = 3,
    parameter int TELLER_W  = 2,
    parameter int SVC_TIME  = 3,
    parameter int WT_W      = 5,
    parameter int TICK_DIV  = 500000
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enter_queue,
    input  logic                leave_queue,
    input  logic [TELLER_W-1:0] tcount,
    output logic [CNT_W-1:0]    pcount,
    output logic [WT_W-1:0]     wtime,
    output logic                full_led,
    output logic                empty_led,
    output logic                alarm,
    output logic [6:0]          seg_units,
    output logic [6:0]          seg_tens,
    output logic [6:0]          seg_count
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int PW = CNT_W + TELLER_W + $clog2(SVC_TIME) + 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              tick_d;

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            tick_d   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            tick_d   <= tick;
        end
    end

    logic [1:0] ent_sync;
    logic [1:0] lv_sync;
    logic       ent_cur;
    logic       ent_prev;
    logic       lv_cur;
    logic       lv_prev;
    logic       up;
    logic       down;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ent_sync <= '0;
            lv_sync  <= '0;
            ent_cur  <= 1'b0;
            ent_prev <= 1'b0;
            lv_cur   <= 1'b0;
            lv_prev  <= 1'b0;
        end else begin
            ent_sync <= {ent_sync[0], enter_queue};
            lv_sync  <= {lv_sync[0], leave_queue};
            if (tick) begin
                ent_prev <= ent_cur;
                ent_cur  <= ent_sync[1];
                lv_prev  <= lv_cur;
                lv_cur   <= lv_sync[1];
            end
        end
    end

    // cur/prev only change on a tick edge; qualifying with the delayed
    // tick turns each rising level into exactly one CLK-wide event.
    assign up   = tick_d & ent_cur & ~ent_prev;
    assign down = tick_d & lv_cur & ~lv_prev;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_n;
    logic             alarm_n;

    always_comb begin
        state_n = state;
        cnt_n   = pcount;
        alarm_n = alarm;
        if (up | down) begin
            unique case (state)
                S_EMPTY: begin
                    if (up) begin
                        cnt_n   = CNT_W'(1);
                        alarm_n = 1'b0;
                    end else begin
                        alarm_n = 1'b1;
                    end
                end
                S_PARTIAL: begin
                    alarm_n = 1'b0;
                    if (up & ~down) begin
                        cnt_n = pcount + CNT_W'(1);
                    end else if (down & ~up) begin
                        cnt_n = pcount - CNT_W'(1);
                    end
                end
                S_FULL: begin
                    if (up & ~down) begin
                        alarm_n = 1'b1;
                    end else begin
                        alarm_n = 1'b0;
                        if (down) begin
                            cnt_n = pcount - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    cnt_n = '0;
                end
            endcase
            if (cnt_n == '0) begin
                state_n = S_EMPTY;
            end else if (cnt_n == CNT_W'(MAX_COUNT)) begin
                state_n = S_FULL;
            end else begin
                state_n = S_PARTIAL;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= S_EMPTY;
            pcount    <= '0;
            alarm     <= 1'b0;
            full_led  <= 1'b0;
            empty_led <= 1'b1;
        end else begin
            state     <= state_n;
            pcount    <= cnt_n;
            alarm     <= alarm_n;
            full_led  <= (state_n == S_FULL);
            empty_led <= (state_n == S_EMPTY);
        end
    end

    // Wait time: ceil-like share of the queue per teller, sized so the
    // product never truncates before the divide.
    logic [PW-1:0]   num;
    logic [PW-1:0]   quo;
    logic [WT_W-1:0] wt_n;

    always_comb begin
        num  = PW'(SVC_TIME) * (PW'(pcount) + PW'(tcount) - PW'(1));
        quo  = '0;
        wt_n = '0;
        if ((pcount != '0) && (tcount != '0)) begin
            quo  = num / PW'(tcount);
            wt_n = WT_W'(quo);
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wtime <= '0;
        end else begin
            wtime <= wt_n;
        end
    end

`ifdef BBQM_SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        unique case (d)
            4'd0: s = 7'h3F;
            4'd1: s = 7'h06;
            4'd2: s = 7'h5B;
            4'd3: s = 7'h4F;
            4'd4: s = 7'h66;
            4'd5: s = 7'h6D;
            4'd6: s = 7'h7D;
            4'd7: s = 7'h07;
            4'd8: s = 7'h7F;
            4'd9: s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    int unsigned wv;
    int unsigned pv;
    logic [3:0]  tens_d;
    logic [3:0]  units_d;
    logic [3:0]  cnt_d;

    always_comb begin
        wv = 32'(wt_n);
        pv = 32'(pcount);
        if (wv > 99) begin
            wv = 99;
        end
        tens_d  = 4'(wv / 10);
        units_d = 4'(wv % 10);
        cnt_d   = (pv > 9) ? 4'd9 : 4'(pv);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            seg_units <= 7'h00;
            seg_tens  <= 7'h00;
            seg_count <= 7'h00;
        end else begin
            seg_units <= seg7(units_d);
            seg_tens  <= seg7(tens_d);
            seg_count <= seg7(cnt_d);
        end
    end
`else
    assign seg_units = 7'h00;
    assign seg_tens  = 7'h00;
    assign seg_count = 7'h00;
`endif

endmodule

// File: tb/tb_bbqm_queue_ctrl.sv
// tb_bbqm_queue_ctrl: scoreboard bench for bbqm_queue_ctrl with a fast
// sample tick (TICK_DIV=4).
module tb_bbqm_queue_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       enter_queue = 1'b0;
    logic       leave_queue = 1'b0;
    logic [1:0] tcount = 2'd1;
    logic [2:0] pcount;
    logic [4:0] wtime;
    logic       full_led;
    logic       empty_led;
    logic       alarm;
    logic [6:0] seg_units;
    logic [6:0] seg_tens;
    logic [6:0] seg_count;

    bbqm_queue_ctrl #(.TICK_DIV(4)) dut (
        .CLK(CLK),
        .reset(reset),
        .enter_queue(enter_queue),
        .leave_queue(leave_queue),
        .tcount(tcount),
        .pcount(pcount),
        .wtime(wtime),
        .full_led(full_led),
        .empty_led(empty_led),
        .alarm(alarm),
        .seg_units(seg_units),
        .seg_tens(seg_tens),
        .seg_count(seg_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int pc;
        bit al;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors = 0;
    int   m_cnt = 0;
    bit   m_alarm = 1'b0;

    function automatic int exp_wt(input int p, input int t);
        if (p == 0 || t == 0) return 0;
        return 3 * (p + t - 1) / t;
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef BBQM_SEG7_EN
        return tbl[d];
`else
        return (d < 0) ? tbl[0] : 7'h00;
`endif
    endfunction

    task automatic model_event(input bit u, input bit d);
        exp_t e;
        if (u && !d) begin
            if (m_cnt == 7) m_alarm = 1'b1;
            else begin m_cnt++; m_alarm = 1'b0; end
        end else if (d && !u) begin
            if (m_cnt == 0) m_alarm = 1'b1;
            else begin m_cnt--; m_alarm = 1'b0; end
        end else if (u && d) begin
            if (m_cnt == 0) m_cnt = 1;
            m_alarm = 1'b0;
        end
        e.pc = m_cnt;
        e.al = m_alarm;
        sb.push_back(e);
    endtask

    task automatic press(input bit u, input bit d);
        model_event(u, d);
        @(negedge CLK);
        enter_queue = u;
        leave_queue = d;
        repeat (12) @(negedge CLK);
        enter_queue = 1'b0;
        leave_queue = 1'b0;
        repeat (12) @(negedge CLK);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++;
        if (pcount !== 3'd0 || empty_led !== 1'b1 || full_led !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: pcount=%0d empty=%b full=%b want 0/1/0",
                     pcount, empty_led, full_led);
        end
        vectors++;
        if (alarm !== 1'b0 || wtime !== 5'd0) begin
            errors++;
            $display("FAIL reset_alarm_wt: alarm=%b wtime=%0d want 0/0", alarm, wtime);
        end
        vectors++;
        if ({seg_units, seg_tens, seg_count} !== 21'd0) begin
            errors++;
            $display("FAIL reset_seg: %h %h %h want 0", seg_units, seg_tens, seg_count);
        end
        reset = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_fill;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            press(1'b1, 1'b0);
            e = sb.pop_front();
            vectors++;
            if (pcount !== 3'(e.pc) || alarm !== e.al) begin
                errors++;
                $display("FAIL fill_%0d: pcount=%0d alarm=%b want %0d/%b",
                         i, pcount, alarm, e.pc, e.al);
            end
            if (i == 6) begin
                vectors++;
                if (full_led !== 1'b1 || wtime !== 5'(exp_wt(7, 1))) begin
                    errors++;
                    $display("FAIL full_wt: full=%b wtime=%0d want 1/%0d",
                             full_led, wtime, exp_wt(7, 1));
                end
                vectors++;
                if (seg_tens !== exp_seg(2) || seg_units !== exp_seg(1) ||
                    seg_count !== exp_seg(7)) begin
                    errors++;
                    $display("FAIL seg_21: tens=%h units=%h cnt=%h want %h/%h/%h",
                             seg_tens, seg_units, seg_count,
                             exp_seg(2), exp_seg(1), exp_seg(7));
                end
            end
        end
    endtask

    task automatic test_reset_midrun;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            press(1'b0, 1'b1);
            e = sb.pop_front();
            vectors++;
            if (pcount !== 3'(e.pc) || alarm !== e.al) begin
                errors++;
                $display("FAIL drain_%0d: pcount=%0d alarm=%b want %0d/%b",
                         i, pcount, alarm, e.pc, e.al);
            end
        end
        @(negedge CLK);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (pcount !== 3'd0 || empty_led !== 1'b1 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pcount=%0d empty=%b alarm=%b want 0/1/0",
                     pcount, empty_led, alarm);
        end
        @(negedge CLK);
        vectors++;
        if (wtime !== 5'd0) begin
            errors++;
            $display("FAIL async_reset_wt: wtime=%0d want 0", wtime);
        end
        reset = 1'b1;
        m_cnt = 0;
        m_alarm = 1'b0;
        sb.delete();
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_empty_leave;
        exp_t e;
        press(1'b0, 1'b1);
        e = sb.pop_front();
        vectors++;
        if (pcount !== 3'(e.pc) || alarm !== e.al) begin
            errors++;
            $display("FAIL empty_leave: pcount=%0d alarm=%b want %0d/%b",
                     pcount, alarm, e.pc, e.al);
        end
        press(1'b1, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (pcount !== 3'(e.pc) || alarm !== e.al || empty_led !== 1'b0) begin
            errors++;
            $display("FAIL recover: pcount=%0d alarm=%b empty=%b want %0d/%b/0",
                     pcount, alarm, empty_led, e.pc, e.al);
        end
    endtask

    task automatic test_hold_glitch;
        exp_t e;
        int   guard;
        model_event(1'b1, 1'b0);
        @(negedge CLK);
        enter_queue = 1'b1;
        repeat (40) @(negedge CLK);
        enter_queue = 1'b0;
        repeat (12) @(negedge CLK);
        e = sb.pop_front();
        vectors++;
        if (pcount !== 3'(e.pc)) begin
            errors++;
            $display("FAIL hold: pcount=%0d want %0d", pcount, e.pc);
        end
        guard = 0;
        while (dut.tick_cnt != 2'd0 && guard < 8) begin
            @(negedge CLK);
            guard++;
        end
        vectors++;
        if (guard >= 8) begin
            errors++;
            $display("FAIL tick_align: no tick wrap within %0d cycles", guard);
        end
        enter_queue = 1'b1;
        @(negedge CLK);
        enter_queue = 1'b0;
        repeat (12) @(negedge CLK);
        vectors++;
        if (pcount !== 3'(m_cnt)) begin
            errors++;
            $display("FAIL glitch: pcount=%0d want %0d", pcount, m_cnt);
        end
    endtask

    task automatic test_wtime;
        exp_t e;
        int   tv [4];
        tv = '{3, 2, 0, 1};
        while (m_cnt < 4) begin
            press(1'b1, 1'b0);
            e = sb.pop_front();
            vectors++;
            if (pcount !== 3'(e.pc)) begin
                errors++;
                $display("FAIL to4: pcount=%0d want %0d", pcount, e.pc);
            end
        end
        foreach (tv[i]) begin
            tcount = 2'(tv[i]);
            repeat (2) @(negedge CLK);
            vectors++;
            if (wtime !== 5'(exp_wt(4, tv[i]))) begin
                errors++;
                $display("FAIL wt_t%0d: wtime=%0d want %0d",
                         tv[i], wtime, exp_wt(4, tv[i]));
            end
        end
        vectors++;
        if (seg_tens !== exp_seg(1) || seg_units !== exp_seg(2) ||
            seg_count !== exp_seg(4)) begin
            errors++;
            $display("FAIL seg_12: tens=%h units=%h cnt=%h want %h/%h/%h",
                     seg_tens, seg_units, seg_count,
                     exp_seg(1), exp_seg(2), exp_seg(4));
        end
        press(1'b1, 1'b1);
        e = sb.pop_front();
        vectors++;
        if (pcount !== 3'(e.pc) || alarm !== e.al) begin
            errors++;
            $display("FAIL both: pcount=%0d alarm=%b want %0d/%b",
                     pcount, alarm, e.pc, e.al);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_reset_midrun;
        test_empty_leave;
        test_hold_glitch;
        test_wtime;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
